// File: rtl/mac_via.sv
// rtl/mac_via.sv - 6522 VIA subset (ports A/B, T1/T2, CA/CB edge interrupts) for the Mac 128 core
// Optional keyboard shift register is compiled in when MAC_VIA_SR_EN is defined.

module mac_via #(
  parameter int c_tick_div = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rw,
  input  logic [3:0] rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pa_dir,
  output logic [7:0] pb_dir,
  input  logic       ca1,
  input  logic       ca2,
  input  logic       cb1,
  input  logic       cb2,
  output logic       irq_n
);

  localparam int pre_w = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;
  localparam logic [pre_w-1:0] pre_last = pre_w'(c_tick_div - 1);

  localparam logic [3:0] r_orb    = 4'd0;
  localparam logic [3:0] r_ora    = 4'd1;
  localparam logic [3:0] r_ddrb   = 4'd2;
  localparam logic [3:0] r_ddra   = 4'd3;
  localparam logic [3:0] r_t1cl   = 4'd4;
  localparam logic [3:0] r_t1ch   = 4'd5;
  localparam logic [3:0] r_t1ll   = 4'd6;
  localparam logic [3:0] r_t1lh   = 4'd7;
  localparam logic [3:0] r_t2cl   = 4'd8;
  localparam logic [3:0] r_t2ch   = 4'd9;
  localparam logic [3:0] r_sr     = 4'd10;
  localparam logic [3:0] r_acr    = 4'd11;
  localparam logic [3:0] r_pcr    = 4'd12;
  localparam logic [3:0] r_ifr    = 4'd13;
  localparam logic [3:0] r_ier    = 4'd14;
  localparam logic [3:0] r_ora_nh = 4'd15;

  logic             wr;
  logic             rd;
  logic [7:0]       ora;
  logic [7:0]       orb;
  logic [7:0]       ddra;
  logic [7:0]       ddrb;
  logic [7:0]       acr;
  logic [7:0]       pcr;
  logic [pre_w-1:0] pre;
  logic             tick;
  logic [15:0]      t1_cnt;
  logic [15:0]      t1_latch;
  logic             t1_armed;
  logic             t1_fire;
  logic [15:0]      t2_cnt;
  logic [7:0]       t2_latch_lo;
  logic             t2_armed;
  logic             t2_fire;
  logic [3:0]       ctl_s1;
  logic [3:0]       ctl_s2;
  logic [3:0]       ctl_d;
  logic [3:0]       edge_sel;
  logic [3:0]       ctl_edge;
  logic [6:0]       ifr;
  logic [6:0]       ier;
  logic [6:0]       ifr_set;
  logic [6:0]       ifr_clr;
  logic             ifr_pend;
  logic             sr_done;
  logic [7:0]       sr_val;
  logic [7:0]       porta_val;
  logic [7:0]       portb_val;
  logic [7:0]       rdata;

  assign wr     = cs & ~rw;
  assign rd     = cs & rw;
  assign pa_out = ora;
  assign pb_out = orb;
  assign pa_dir = ddra;
  assign pb_dir = ddrb;

  assign porta_val = (pa_in & ~ddra) | (ora & ddra);
  assign portb_val = (pb_in & ~ddrb) | (orb & ddrb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ora  <= 8'h00;
      orb  <= 8'h00;
      ddra <= 8'h00;
      ddrb <= 8'h00;
      acr  <= 8'h00;
      pcr  <= 8'h00;
    end else if (wr) begin
      case (rs)
        r_orb:           orb  <= din;
        r_ora, r_ora_nh: ora  <= din;
        r_ddrb:          ddrb <= din;
        r_ddra:          ddra <= din;
        r_acr:           acr  <= din;
        r_pcr:           pcr  <= din;
        default: ;
      endcase
    end
  end

  // Free-running E-clock prescaler; timer writes never realign it.
  assign tick = (pre == pre_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  assign t1_fire = tick && (t1_cnt == 16'h0000) && (acr[6] || t1_armed)
                   && !(wr && rs == r_t1ch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t1_cnt   <= 16'h0000;
      t1_latch <= 16'h0000;
      t1_armed <= 1'b0;
    end else begin
      if (wr && (rs == r_t1cl || rs == r_t1ll)) t1_latch[7:0]  <= din;
      if (wr && (rs == r_t1lh || rs == r_t1ch)) t1_latch[15:8] <= din;
      if (wr && rs == r_t1ch) begin
        t1_cnt   <= {din, t1_latch[7:0]};
        t1_armed <= 1'b1;
      end else if (tick) begin
        if (t1_cnt != 16'h0000) begin
          t1_cnt <= t1_cnt - 16'h0001;
        end else if (acr[6]) begin
          t1_cnt <= t1_latch;
        end else begin
          t1_cnt   <= 16'hFFFF;
          t1_armed <= 1'b0;
        end
      end
    end
  end

  assign t2_fire = tick && (t2_cnt == 16'h0000) && t2_armed && !(wr && rs == r_t2ch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t2_cnt      <= 16'h0000;
      t2_latch_lo <= 8'h00;
      t2_armed    <= 1'b0;
    end else begin
      if (wr && rs == r_t2cl) t2_latch_lo <= din;
      if (wr && rs == r_t2ch) begin
        t2_cnt   <= {din, t2_latch_lo};
        t2_armed <= 1'b1;
      end else if (tick) begin
        t2_cnt <= t2_cnt - 16'h0001;
        if (t2_cnt == 16'h0000) t2_armed <= 1'b0;
      end
    end
  end

  // Control inputs: index 0 ca1, 1 ca2, 2 cb1, 3 cb2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_s1 <= 4'h0;
      ctl_s2 <= 4'h0;
      ctl_d  <= 4'h0;
    end else begin
      ctl_s1 <= {cb2, cb1, ca2, ca1};
      ctl_s2 <= ctl_s1;
      ctl_d  <= ctl_s2;
    end
  end

  assign edge_sel = {pcr[6], pcr[4], pcr[2], pcr[0]};
  assign ctl_edge = (ctl_s2 & ~ctl_d & edge_sel) | (~ctl_s2 & ctl_d & ~edge_sel);

`ifdef MAC_VIA_SR_EN
  logic [7:0] sr;
  logic [2:0] sr_cnt;
  logic       sr_shift;
  logic       sr_access;

  assign sr_access = cs && (rs == r_sr);
  assign sr_shift  = ctl_s2[2] && !ctl_d[2] && (acr[4:2] == 3'b011);
  assign sr_done   = sr_shift && (sr_cnt == 3'd7) && !sr_access;
  assign sr_val    = sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr     <= 8'h00;
      sr_cnt <= 3'd0;
    end else if (sr_access) begin
      sr_cnt <= 3'd0;
      if (!rw) sr <= din;
    end else if (sr_shift) begin
      sr     <= {sr[6:0], ctl_s2[3]};
      sr_cnt <= sr_cnt + 3'd1;
    end
  end
`else
  assign sr_done = 1'b0;
  assign sr_val  = 8'h00;
`endif

  assign ifr_set  = {t1_fire, t2_fire, ctl_edge[2], ctl_edge[3], sr_done, ctl_edge[0], ctl_edge[1]};
  assign ifr_pend = |(ifr & ier);

  always_comb begin
    ifr_clr = 7'h00;
    if (cs && rs == r_ora) ifr_clr[1:0] = 2'b11;
    if (cs && rs == r_orb) ifr_clr[4:3] = 2'b11;
    if (cs && rs == r_sr)  ifr_clr[2]   = 1'b1;
    if (wr && rs == r_ifr) ifr_clr      = ifr_clr | din[6:0];
    if ((wr && (rs == r_t1lh || rs == r_t1ch)) || (rd && rs == r_t1cl)) ifr_clr[6] = 1'b1;
    if ((wr && rs == r_t2ch) || (rd && rs == r_t2cl)) ifr_clr[5] = 1'b1;
  end

  // Set terms are OR'd in after clears so a coincident set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifr   <= 7'h00;
      ier   <= 7'h00;
      irq_n <= 1'b1;
    end else begin
      ifr   <= (ifr & ~ifr_clr) | ifr_set;
      irq_n <= ~ifr_pend;
      if (wr && rs == r_ier) begin
        if (din[7]) ier <= ier | din[6:0];
        else        ier <= ier & ~din[6:0];
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (rs)
      r_orb:           rdata = portb_val;
      r_ora, r_ora_nh: rdata = porta_val;
      r_ddrb:          rdata = ddrb;
      r_ddra:          rdata = ddra;
      r_t1cl:          rdata = t1_cnt[7:0];
      r_t1ch:          rdata = t1_cnt[15:8];
      r_t1ll:          rdata = t1_latch[7:0];
      r_t1lh:          rdata = t1_latch[15:8];
      r_t2cl:          rdata = t2_cnt[7:0];
      r_t2ch:          rdata = t2_cnt[15:8];
      r_sr:            rdata = sr_val;
      r_acr:           rdata = acr;
      r_pcr:           rdata = pcr;
      r_ifr:           rdata = {ifr_pend, ifr};
      r_ier:           rdata = {1'b1, ier};
      default:         rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  dout <= 8'h00;
    else if (rd)   dout <= rdata;
  end

endmodule

// File: tb/tb_mac_via.sv
// tb/tb_mac_via.sv - self-checking bench for mac_via (register table, random port/IER model, timing sequences)
// Expectations for the shift register follow MAC_VIA_SR_EN.

module tb_mac_via;

  localparam int td = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0;
  logic       rw = 1'b1;
  logic [3:0] rs = 4'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] pa_in = 8'h00;
  logic [7:0] pb_in = 8'h00;
  logic [7:0] pa_out, pb_out, pa_dir, pb_dir;
  logic       ca1 = 1'b0, ca2 = 1'b0, cb1 = 1'b0, cb2 = 1'b0;
  logic       irq_n;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc;
  int last_edge;

  mac_via #(.c_tick_div(td)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .rw(rw), .rs(rs), .din(din), .dout(dout),
    .pa_in(pa_in), .pb_in(pb_in), .pa_out(pa_out), .pb_out(pb_out),
    .pa_dir(pa_dir), .pb_dir(pb_dir),
    .ca1(ca1), .ca2(ca2), .cb1(cb1), .cb2(cb2), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  // Rising-edge count since reset release; the prescaler ticks on every td-th edge.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ncyc <= 0;
    else          ncyc <= ncyc + 1;

  typedef struct {
    logic       wr;
    logic [3:0] rs;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] e);
    vec_t v;
    v.wr = w; v.rs = a; v.din = d; v.exp = e;
    return v;
  endfunction

  function automatic int next_tick(input int w);
    return (w / td + 1) * td;
  endfunction

  function automatic logic [7:0] port_model(input logic [7:0] pin, input logic [7:0] ddr,
                                            input logic [7:0] orv);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = ddr[b] ? orv[b] : pin[b];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; rs = a; din = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
    last_edge = ncyc;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; rs = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
    last_edge = ncyc;
  endtask

  task automatic wait_irq(input logic lvl, input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq_n === lvl) begin
        seen = ncyc;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] ddra_m, ora_m, ddrb_m, orb_m;
    logic [6:0] ier_m;
    int e, e1, e2, e3, n0, w, f, lows;
    logic [7:0] sr_exp;
    logic [7:0] pat;

    idle(3);
    reset_n = 1'b1;
    idle(2);
    check("reset_irq_n", irq_n, 1);
    check("reset_pa_out", pa_out, 8'h00);
    check("reset_pa_dir", pa_dir, 8'h00);
    check("reset_pb_out", pb_out, 8'h00);
    check("reset_pb_dir", pb_dir, 8'h00);
    check("reset_dout", dout, 8'h00);

    pa_in = 8'h3C;
    pb_in = 8'h99;
    tbl.push_back(mk(1'b0, 4'd14, 8'h00, 8'h80));
    tbl.push_back(mk(1'b0, 4'd13, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 4'd3,  8'hF0, 8'h00));
    tbl.push_back(mk(1'b1, 4'd1,  8'hA5, 8'h00));
    tbl.push_back(mk(1'b0, 4'd1,  8'h00, 8'hAC));
    tbl.push_back(mk(1'b0, 4'd15, 8'h00, 8'hAC));
    tbl.push_back(mk(1'b0, 4'd3,  8'h00, 8'hF0));
    tbl.push_back(mk(1'b0, 4'd0,  8'h00, 8'h99));
    tbl.push_back(mk(1'b1, 4'd2,  8'h0F, 8'h00));
    tbl.push_back(mk(1'b0, 4'd0,  8'h00, 8'h90));
    tbl.push_back(mk(1'b1, 4'd12, 8'h11, 8'h00));
    tbl.push_back(mk(1'b0, 4'd12, 8'h00, 8'h11));
    tbl.push_back(mk(1'b1, 4'd12, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 4'd11, 8'h23, 8'h00));
    tbl.push_back(mk(1'b0, 4'd11, 8'h00, 8'h23));
    tbl.push_back(mk(1'b1, 4'd11, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 4'd6,  8'h34, 8'h00));
    tbl.push_back(mk(1'b1, 4'd7,  8'h12, 8'h00));
    tbl.push_back(mk(1'b0, 4'd6,  8'h00, 8'h34));
    tbl.push_back(mk(1'b0, 4'd7,  8'h00, 8'h12));
    tbl.push_back(mk(1'b0, 4'd10, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 4'd14, 8'h00, 8'h80));
    foreach (tbl[i]) begin
      if (tbl[i].wr) bus_write(tbl[i].rs, tbl[i].din);
      else begin
        bus_read(tbl[i].rs, d);
        check($sformatf("tbl%0d_rs%0d", i, tbl[i].rs), d, tbl[i].exp);
      end
    end
    check("porta_out_a5", pa_out, 8'hA5);

    for (int it = 0; it < 12; it++) begin
      ddra_m = 8'($urandom_range(0, 255));
      ora_m  = 8'($urandom_range(0, 255));
      ddrb_m = 8'($urandom_range(0, 255));
      orb_m  = 8'($urandom_range(0, 255));
      pa_in  = 8'($urandom_range(0, 255));
      pb_in  = 8'($urandom_range(0, 255));
      bus_write(4'd3, ddra_m);
      bus_write(4'd15, ora_m);
      bus_write(4'd2, ddrb_m);
      bus_write(4'd0, orb_m);
      bus_read(4'd1, d);
      check("rnd_porta", d, port_model(pa_in, ddra_m, ora_m));
      bus_read(4'd0, d);
      check("rnd_portb", d, port_model(pb_in, ddrb_m, orb_m));
      check("rnd_pa_out", pa_out, ora_m);
      check("rnd_pb_dir", pb_dir, ddrb_m);
    end

    bus_write(4'd14, 8'h7F);
    ier_m = 7'h00;
    for (int it = 0; it < 12; it++) begin
      d = 8'($urandom_range(0, 255));
      bus_write(4'd14, d);
      if (d[7]) ier_m = ier_m | d[6:0];
      else      ier_m = ier_m & ~d[6:0];
      bus_read(4'd14, d);
      check("rnd_ier", d, {1'b1, ier_m});
    end

    // CA1 falling edge through to irq_n, cleared by rs 1 but not by rs 15.
    bus_write(4'd14, 8'h7F);
    bus_write(4'd13, 8'h7F);
    bus_write(4'd12, 8'h00);
    bus_write(4'd14, 8'h82);
    ca1 = 1'b1;
    idle(6);
    check("ca1_rise_no_irq", irq_n, 1);
    @(negedge clk);
    ca1 = 1'b0;
    n0 = ncyc;
    wait_irq(1'b0, 20, e);
    check("ca1_irq_latency", e, n0 + 4);
    bus_read(4'd1, d);
    check("ca1_irq_held", irq_n, 0);
    @(negedge clk);
    check("ca1_clear_rs1", irq_n, 1);
    ca1 = 1'b1;
    idle(6);
    @(negedge clk);
    ca1 = 1'b0;
    n0 = ncyc;
    wait_irq(1'b0, 20, e);
    check("ca1_irq_latency2", e, n0 + 4);
    bus_read(4'd15, d);
    idle(3);
    check("ca1_rs15_no_clear", irq_n, 0);
    bus_write(4'd13, 8'h02);
    @(negedge clk);
    check("ca1_ifr_write_clear", irq_n, 1);

    // T1 one-shot: load 5, flag on the 6th tick after the load.
    bus_write(4'd14, 8'h7F);
    bus_write(4'd13, 8'h7F);
    bus_write(4'd11, 8'h00);
    bus_write(4'd14, 8'hC0);
    bus_write(4'd6, 8'h05);
    bus_write(4'd5, 8'h00);
    w = last_edge;
    wait_irq(1'b0, 80, e);
    check("t1_oneshot_time", e, next_tick(w) + 5 * td + 1);
    idle(30);
    check("t1_flag_sticky", irq_n, 0);
    bus_read(4'd4, d);
    @(negedge clk);
    check("t1cl_read_clear", irq_n, 1);
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (irq_n !== 1'b1) lows++;
    end
    check("t1_oneshot_once", lows, 0);

    // T1 free-run: flags every 6 ticks; a T1CH write on the underflow edge wins.
    bus_write(4'd11, 8'h40);
    bus_write(4'd6, 8'h05);
    bus_write(4'd5, 8'h00);
    w = last_edge;
    wait_irq(1'b0, 80, e1);
    check("t1_free_first", e1, next_tick(w) + 5 * td + 1);
    bus_read(4'd4, d);
    wait_irq(1'b0, 80, e2);
    check("t1_free_period", e2 - e1, 6 * td);
    bus_read(4'd4, d);
    f = e2 - 1;
    for (int i = 0; i < 60 && ncyc < f + 6 * td - 2; i++) @(negedge clk);
    bus_write(4'd5, 8'h00);
    w = last_edge;
    wait_irq(1'b0, 80, e3);
    check("t1_write_beats_underflow", e3, w + 6 * td + 1);
    bus_write(4'd11, 8'h00);

    // T2 one-shot: load 3, flag on the 4th tick.
    bus_write(4'd14, 8'h7F);
    bus_write(4'd13, 8'h7F);
    bus_write(4'd14, 8'hA0);
    bus_write(4'd8, 8'h03);
    bus_write(4'd9, 8'h00);
    w = last_edge;
    wait_irq(1'b0, 60, e);
    check("t2_oneshot_time", e, next_tick(w) + 3 * td + 1);
    bus_read(4'd8, d);
    @(negedge clk);
    check("t2cl_read_clear", irq_n, 1);

    // Shift register: 8 cb1 rising edges carrying 0x5A on cb2.
    bus_write(4'd14, 8'h7F);
    bus_write(4'd13, 8'h7F);
    bus_write(4'd11, 8'h0C);
    pat = 8'h5A;
    for (int b = 7; b >= 0; b--) begin
      @(negedge clk);
      cb2 = pat[b];
      idle(3);
      cb1 = 1'b1;
      idle(4);
      cb1 = 1'b0;
      idle(4);
    end
`ifdef MAC_VIA_SR_EN
    sr_exp = 8'h5A;
`else
    sr_exp = 8'h00;
`endif
    bus_read(4'd13, d);
    check("sr_ifr2_after_8", d & 8'h04, (sr_exp != 8'h00) ? 8'h04 : 8'h00);
    bus_read(4'd10, d);
    check("sr_value", d, sr_exp);
    bus_read(4'd13, d);
    check("sr_ifr2_cleared", d & 8'h04, 8'h00);
    bus_write(4'd11, 8'h00);

    // Reset asserted in the middle of a write strobe.
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; rs = 4'd3; din = 8'h55;
    #2 reset_n = 1'b0;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
    reset_n = 1'b1;
    idle(2);
    check("midreset_pa_dir", pa_dir, 8'h00);
    check("midreset_pa_out", pa_out, 8'h00);
    check("midreset_irq_n", irq_n, 1);
    bus_read(4'd14, d);
    check("midreset_ier", d, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
